// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel clock-enable divider, h/v counters, sync/blank decode
// and a pixel-tick delay line that keeps syncs aligned with the pixel pipeline.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned PIPE_DELAY = 1,
  parameter int unsigned COORD_W    = 10
) (
  input  logic               master_clk,
  input  logic               reset,
  input  logic               run,
  output logic               pixel_ce,
  output logic [COORD_W-1:0] xPixel,
  output logic [COORD_W-1:0] yPixel,
  output logic               display_area,
  output logic               blank_n,
  output logic               VGA_hSync,
  output logic               VGA_vSync,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Sync bits are carried at their output level so the last stage drives pins directly.
  typedef struct packed {
    logic active;
    logic hs_lvl;
    logic vs_lvl;
    logic ls;
    logic fs;
  } dec_t;

  localparam dec_t DEC_IDLE = '{
    active: 1'b0,
    hs_lvl: ~H_SYNC_POL,
    vs_lvl: ~V_SYNC_POL,
    ls:     1'b0,
    fs:     1'b0
  };

  logic [DIV_W-1:0]   div_q;
  logic               pixel_ce_q;
  logic [COORD_W-1:0] h_q;
  logic [COORD_W-1:0] v_q;
  dec_t               dec_c;
  dec_t               pipe_q [PIPE_DELAY];
  dec_t               pipe_last;

  // Pixel clock-enable divider; run low holds it cleared.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      pixel_ce_q <= 1'b0;
    end else if (!run) begin
      div_q      <= '0;
      pixel_ce_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q      <= '0;
      pixel_ce_q <= 1'b1;
    end else begin
      div_q      <= div_q + DIV_W'(1);
      pixel_ce_q <= 1'b0;
    end
  end

  // Horizontal/vertical position counters, advanced once per pixel tick.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!run) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pixel_ce_q) begin
      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + COORD_W'(1);
      end else begin
        h_q <= h_q + COORD_W'(1);
      end
    end
  end

  // Decode of the current position, before the delay line.
  always_comb begin
    dec_c        = DEC_IDLE;
    dec_c.active = (h_q < H_ACT) && (v_q < V_ACT);
    dec_c.hs_lvl = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? H_SYNC_POL : ~H_SYNC_POL;
    dec_c.vs_lvl = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? V_SYNC_POL : ~V_SYNC_POL;
    dec_c.ls     = (h_q == '0);
    dec_c.fs     = (h_q == '0) && (v_q == '0);
  end

  // Delay line matching the pixel pipeline latency; flushed while idle.
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= DEC_IDLE;
    end else if (!run) begin
      for (int unsigned i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= DEC_IDLE;
    end else if (pixel_ce_q) begin
      pipe_q[0] <= dec_c;
      for (int unsigned i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pipe_last    = pipe_q[PIPE_DELAY-1];
  assign pixel_ce     = pixel_ce_q;
  assign xPixel       = h_q;
  assign yPixel       = v_q;
  assign display_area = pipe_last.active;
  assign blank_n      = pipe_last.active;
  assign VGA_hSync    = pipe_last.hs_lvl;
  assign VGA_vSync    = pipe_last.vs_lvl;
  assign line_start   = pipe_last.ls;
  assign frame_start  = pipe_last.fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three configurations share clock, reset and run.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int div; int pd;
    bit hpol; bit vpol;
  } cfg_t;

  typedef struct packed {
    logic       ce;
    logic [9:0] x;
    logic [9:0] y;
    logic       da;
    logic       bn;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  localparam cfg_t CFG_A = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33,
                             div:2, pd:1, hpol:1'b0, vpol:1'b0};
  localparam cfg_t CFG_B = '{ha:8, hfp:2, hs:3, hbp:2, va:4, vfp:1, vs:2, vbp:1,
                             div:3, pd:2, hpol:1'b1, vpol:1'b1};
  localparam cfg_t CFG_C = '{ha:4, hfp:1, hs:2, hbp:1, va:3, vfp:1, vs:1, vbp:1,
                             div:1, pd:3, hpol:1'b0, vpol:1'b0};
  localparam int LIM = 4000;

  logic master_clk = 1'b0;
  logic reset;
  logic run;

  logic a_ce, a_da, a_bn, a_hs, a_vs, a_ls, a_fs;
  logic b_ce, b_da, b_bn, b_hs, b_vs, b_ls, b_fs;
  logic c_ce, c_da, c_bn, c_hs, c_vs, c_ls, c_fs;
  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  obs_t obs_a, obs_b, obs_c;

  int checks = 0;
  int errors = 0;
  int k = 0;

  always #5 master_clk = ~master_clk;

  vga_timing_gen dut_a (
    .master_clk(master_clk), .reset(reset), .run(run), .pixel_ce(a_ce),
    .xPixel(a_x), .yPixel(a_y), .display_area(a_da), .blank_n(a_bn),
    .VGA_hSync(a_hs), .VGA_vSync(a_vs), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(3), .PIPE_DELAY(2), .COORD_W(10)
  ) dut_b (
    .master_clk(master_clk), .reset(reset), .run(run), .pixel_ce(b_ce),
    .xPixel(b_x), .yPixel(b_y), .display_area(b_da), .blank_n(b_bn),
    .VGA_hSync(b_hs), .VGA_vSync(b_vs), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CLK_DIV(1), .PIPE_DELAY(3), .COORD_W(10)
  ) dut_c (
    .master_clk(master_clk), .reset(reset), .run(run), .pixel_ce(c_ce),
    .xPixel(c_x), .yPixel(c_y), .display_area(c_da), .blank_n(c_bn),
    .VGA_hSync(c_hs), .VGA_vSync(c_vs), .line_start(c_ls), .frame_start(c_fs)
  );

  assign obs_a = {a_ce, a_x, a_y, a_da, a_bn, a_hs, a_vs, a_ls, a_fs};
  assign obs_b = {b_ce, b_x, b_y, b_da, b_bn, b_hs, b_vs, b_ls, b_fs};
  assign obs_c = {c_ce, c_x, c_y, c_da, c_bn, c_hs, c_vs, c_ls, c_fs};

  task automatic chk(input string tag, input string field, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", tag, field, act, exp, $time);
    end
  endtask

  // Expected outputs after k consecutive run-high edges since the last clear.
  // Ticks taken: one per CLK_DIV edges, the first counter step on edge CLK_DIV+1.
  function automatic obs_t model(input cfg_t c, input int kk);
    obs_t o;
    int ht, vt, n, cnt, h, v;
    ht   = c.ha + c.hfp + c.hs + c.hbp;
    vt   = c.va + c.vfp + c.vs + c.vbp;
    o.ce = (kk > 0) && (kk % c.div == 0);
    n    = (kk > 0) ? (kk - 1) / c.div : 0;
    o.x  = 10'(n % ht);
    o.y  = 10'((n / ht) % vt);
    o.da = 1'b0;
    o.hs = ~c.hpol;
    o.vs = ~c.vpol;
    o.ls = 1'b0;
    o.fs = 1'b0;
    if (n >= c.pd) begin
      cnt  = n - c.pd;
      h    = cnt % ht;
      v    = (cnt / ht) % vt;
      o.da = (h < c.ha) && (v < c.va);
      o.hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.hpol : ~c.hpol;
      o.vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.vpol : ~c.vpol;
      o.ls = (h == 0);
      o.fs = (h == 0) && (v == 0);
    end
    o.bn = o.da;
    return o;
  endfunction

  task automatic cmp_dut(input string tag, input obs_t act, input obs_t exp);
    chk(tag, "pixel_ce",     int'(act.ce), int'(exp.ce));
    chk(tag, "xPixel",       int'(act.x),  int'(exp.x));
    chk(tag, "yPixel",       int'(act.y),  int'(exp.y));
    chk(tag, "display_area", int'(act.da), int'(exp.da));
    chk(tag, "blank_n",      int'(act.bn), int'(exp.bn));
    chk(tag, "VGA_hSync",    int'(act.hs), int'(exp.hs));
    chk(tag, "VGA_vSync",    int'(act.vs), int'(exp.vs));
    chk(tag, "line_start",   int'(act.ls), int'(exp.ls));
    chk(tag, "frame_start",  int'(act.fs), int'(exp.fs));
  endtask

  // Cycle-by-cycle comparison of every DUT against the model.
  initial begin
    forever begin
      @(posedge master_clk);
      if (reset || !run) k = 0;
      else k = k + 1;
      #1;
      cmp_dut("dut_a", obs_a, model(CFG_A, k));
      cmp_dut("dut_b", obs_b, model(CFG_B, k));
      cmp_dut("dut_c", obs_c, model(CFG_C, k));
    end
  end

  function automatic logic sig(input int id);
    case (id)
      0:       return a_hs;
      1:       return b_hs;
      2:       return b_vs;
      default: return c_fs;
    endcase
  endfunction

  task automatic step();
    @(posedge master_clk);
    #1;
  endtask

  // Width in master cycles of the next complete pulse at level lvl.
  task automatic pulse_width(input string name, input int id, input logic lvl, input int exp);
    int n;
    n = 0;
    while (sig(id) == lvl && n < LIM) begin step(); n++; end
    n = 0;
    while (sig(id) != lvl && n < LIM) begin step(); n++; end
    n = 0;
    while (sig(id) == lvl && n < LIM) begin step(); n++; end
    chk("pulse", name, n, exp);
  endtask

  task automatic wait_x300();
    int n;
    n = 0;
    while (a_x != 10'd300 && n < LIM) begin step(); n++; end
    chk("wait", "a_x_reaches_300", int'(a_x), 300);
  endtask

  initial begin
    int n, da_cnt, ls_cnt, fs_cnt;
    reset = 1'b1;
    run   = 1'b0;
    repeat (3) @(negedge master_clk);

    chk("reset", "a_hSync_idle", int'(a_hs), 1);
    chk("reset", "a_vSync_idle", int'(a_vs), 1);
    chk("reset", "b_hSync_idle", int'(b_hs), 0);
    chk("reset", "b_vSync_idle", int'(b_vs), 0);
    chk("reset", "a_blank_n",    int'(a_bn), 0);

    // Start: first pixel_ce on edge 2, display rises as x steps 0->1.
    @(negedge master_clk);
    reset = 1'b0;
    run   = 1'b1;
    step(); chk("start", "a_ce_edge1", int'(a_ce), 0);
    step(); chk("start", "a_ce_edge2", int'(a_ce), 1);
    chk("start", "a_da_edge2", int'(a_da), 0);
    step(); chk("start", "a_x_edge3", int'(a_x), 1);
    chk("start", "a_da_edge3", int'(a_da), 1);
    chk("start", "a_fs_edge3", int'(a_fs), 1);

    // Default hsync: first low sample at x=657, low for 96 ticks.
    n = 0;
    while (a_hs != 1'b0 && n < LIM) begin step(); n++; end
    chk("hsync", "a_first_low_x", int'(a_x), 657);
    pulse_width("a_hsync_low", 0, 1'b0, 192);
    pulse_width("b_hsync_high", 1, 1'b1, 9);
    pulse_width("b_vsync_high", 2, 1'b1, 90);

    // Small config: one frame of 48 cycles has 12 active, 6 line starts, 1 frame start.
    n = 0;
    while (c_fs != 1'b1 && n < LIM) begin step(); n++; end
    da_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      da_cnt += int'(c_da);
      ls_cnt += int'(c_ls);
      fs_cnt += int'(c_fs);
      step();
    end
    chk("frame", "c_display_ticks", da_cnt, 12);
    chk("frame", "c_line_starts",   ls_cnt, 6);
    chk("frame", "c_frame_starts",  fs_cnt, 1);
    chk("frame", "c_next_fs",       int'(c_fs), 1);

    // Mid-line asynchronous reset.
    wait_x300();
    #2 reset = 1'b1;
    #1;
    chk("areset", "a_x",  int'(a_x),  0);
    chk("areset", "a_ce", int'(a_ce), 0);
    chk("areset", "a_da", int'(a_da), 0);
    chk("areset", "a_hs", int'(a_hs), 1);
    chk("areset", "b_vs", int'(b_vs), 0);
    repeat (2) @(negedge master_clk);
    reset = 1'b0;
    step(); chk("restart", "a_ce_edge1", int'(a_ce), 0);
    step(); chk("restart", "a_ce_edge2", int'(a_ce), 1);
    chk("restart", "a_x_edge2", int'(a_x), 0);

    // Clear wins when run drops on a pixel_ce edge.
    repeat (20) step();
    n = 0;
    while (a_ce != 1'b1 && n < 10) begin step(); n++; end
    @(negedge master_clk);
    run = 1'b0;
    step();
    chk("prio", "a_x_cleared", int'(a_x), 0);
    chk("prio", "a_ce_low",    int'(a_ce), 0);
    @(negedge master_clk);
    run = 1'b1;

    // Drop run mid-line for 10 cycles.
    n = 0;
    while (a_x != 10'd100 && n < LIM) begin step(); n++; end
    @(negedge master_clk);
    run = 1'b0;
    step();
    chk("idle", "a_x",  int'(a_x),  0);
    chk("idle", "a_da", int'(a_da), 0);
    chk("idle", "a_hs", int'(a_hs), 1);
    repeat (9) @(negedge master_clk);
    chk("idle", "a_y_held", int'(a_y), 0);
    run = 1'b1;
    step(); chk("rerun", "a_fs_edge1", int'(a_fs), 0);
    step(); chk("rerun", "a_fs_edge2", int'(a_fs), 0);
    step(); chk("rerun", "a_fs_edge3", int'(a_fs), 1);
    chk("rerun", "c_fs_edge3", int'(c_fs), 0);
    step(); chk("rerun", "c_fs_edge4", int'(c_fs), 1);

    // Free run across many small-config frames and several default lines.
    repeat (12000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
